// File: rtl/typedefs_pkg.sv
// typedefs: shared VeriRISC opcode and controller state encodings
//   opcode_t : 3-bit instruction opcode as held in the instruction register
//   state_t  : 3-bit controller phase, one value per clock of the 8-phase cycle
package typedefs;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

endpackage

// File: rtl/controller.sv
// controller: VeriRISC 8-phase instruction sequencer with sticky halt
//   clk, rst          : clock, synchronous active-high reset
//   opcode, zero      : current instruction opcode and ALU accumulator-zero flag
//   mem_rd, mem_wr    : memory read / write enables
//   load_ir, load_ac  : instruction register / accumulator load strobes
//   inc_pc, load_pc   : program counter increment / jump load
//   halt              : CPU halted indication
//   phase             : current state encoding
import typedefs::*;

module controller (
    input  logic       clk,
    input  logic       rst,
    input  opcode_t    opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       load_ac,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       halt,
    output logic [2:0] phase
);
    state_t state;
    logic   halted;
    logic   aluop;
    logic   hlt_now;
    logic   run;

    assign aluop   = opcode inside {ADD, AND, XOR, LDA};
    assign hlt_now = state == OP_ADDR && opcode == HLT;
    assign run     = !halted;

    // A HLT in OP_ADDR parks the sequencer in OP_ADDR; the 3-bit state
    // wraps naturally from STORE back to INST_ADDR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            if (hlt_now)
                halted <= 1'b1;
            state <= (halted || hlt_now) ? OP_ADDR : state_t'(state + 3'd1);
        end
    end

    // While halted every strobe but halt is suppressed, even if the
    // state register was disturbed away from OP_ADDR.
    assign mem_rd  = run && (state inside {INST_FETCH, INST_LOAD, IDLE} ||
                             (state inside {OP_FETCH, ALU_OP, STORE} && aluop));
    assign mem_wr  = run && state == STORE && opcode == STO;
    assign load_ir = run && state inside {INST_LOAD, IDLE};
    assign load_ac = run && state inside {ALU_OP, STORE} && aluop;
    assign inc_pc  = run && (state == OP_ADDR ||
                             (state == ALU_OP && opcode == SKZ && zero) ||
                             (state == STORE && opcode == JMP));
    assign load_pc = run && state inside {ALU_OP, STORE} && opcode == JMP;
    assign halt    = halted || hlt_now;
    assign phase   = state;

endmodule

// File: tb/tb_controller.sv
// tb_controller: scoreboard bench for the VeriRISC controller
import typedefs::*;

module tb_controller;
    logic       clk = 1'b0;
    logic       rst;
    opcode_t    opcode;
    logic       zero;
    logic       mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt;
    logic [2:0] phase;

    typedef struct {
        logic [10:0] v;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    string       tag = "init";
    logic [2:0]  ms;
    logic        mh;
    logic        mvalid = 1'b0;

    controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir), .load_ac(load_ac),
        .inc_pc(inc_pc), .load_pc(load_pc), .halt(halt), .phase(phase)
    );

    always #5 clk = ~clk;

    // Packing: {phase, halt, load_pc, inc_pc, load_ac, load_ir, mem_wr, mem_rd}
    function automatic logic [10:0] ref_out(logic [2:0] ph, opcode_t o, logic z, logic h);
        logic alu, rd, wr, ir, ac, inc, ld, hl;
        alu = (o == ADD) || (o == AND) || (o == XOR) || (o == LDA);
        {rd, wr, ir, ac, inc, ld, hl} = '0;
        if (h) begin
            hl = 1'b1;
        end else begin
            case (ph)
                3'd1: rd = 1'b1;
                3'd2, 3'd3: begin rd = 1'b1; ir = 1'b1; end
                3'd4: begin inc = 1'b1; hl = (o == HLT); end
                3'd5: rd = alu;
                3'd6: begin rd = alu; ac = alu; inc = (o == SKZ) && z; ld = (o == JMP); end
                3'd7: begin rd = alu; ac = alu; inc = (o == JMP); ld = (o == JMP); wr = (o == STO); end
                default: ;
            endcase
        end
        return {ph, hl, ld, inc, ac, ir, wr, rd};
    endfunction

    function automatic logic [10:0] dut_out();
        return {phase, halt, load_pc, inc_pc, load_ac, load_ir, mem_wr, mem_rd};
    endfunction

    // Monitor: the DUT presents a fresh output vector every cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [10:0] a;
            e = q.pop_front();
            a = dut_out();
            checks++;
            if (a !== e.v) begin
                errors++;
                $display("FAIL %s: got %b required %b (phase/halt/ld_pc/inc_pc/ld_ac/ld_ir/wr/rd)", e.tag, a, e.v);
            end
            checks++;
            if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
                errors++;
                $display("FAIL %s rdwr_excl: got rd=%b wr=%b required not both 1", e.tag, mem_rd, mem_wr);
            end
        end
    end

    task automatic step(input logic r, input opcode_t o, input logic z);
        exp_t e;
        rst = r;
        opcode = o;
        zero = z;
        if (mvalid) begin
            e.v = ref_out(ms, o, z, mh);
            e.tag = tag;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            ms = 3'd0;
            mh = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (mh || (ms == 3'd4 && o == HLT)) begin
                if (!mh && ms == 3'd4) mh = 1'b1;
                ms = 3'd4;
            end else begin
                ms = ms + 3'd1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [10:0] want);
        checks++;
        if (dut_out() !== want) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, dut_out(), want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete required in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        opcode = ADD;
        zero = 1'b0;
        tag = "reset";
        repeat (2) step(1'b1, ADD, 1'b0);
        chk("reset_state", 11'b000_0000000);
        tag = "seq_add";
        repeat (16) step(1'b0, ADD, 1'b0);
        tag = "skz_z1";
        repeat (8) step(1'b0, SKZ, 1'b1);
        tag = "skz_z0";
        repeat (8) step(1'b0, SKZ, 1'b0);
        tag = "jmp";
        repeat (8) step(1'b0, JMP, 1'b0);
        tag = "sto";
        repeat (8) step(1'b0, STO, 1'b1);
        tag = "hlt";
        repeat (4) step(1'b0, HLT, 1'b0);
        chk("hlt_enter", 11'b100_1010000);
        repeat (20) step(1'b0, HLT, 1'b0);
        tag = "hlt_add";
        repeat (5) step(1'b0, ADD, 1'b1);
        chk("hlt_sticky", 11'b100_1000000);
        tag = "hlt_rst";
        step(1'b1, ADD, 1'b0);
        chk("hlt_cleared", 11'b000_0000000);
        tag = "mid_rst";
        repeat (6) step(1'b0, LDA, 1'b0);
        chk("lda_phase6", 11'b110_0001001);
        step(1'b1, LDA, 1'b0);
        chk("mid_rst_out", 11'b000_0000000);
        tag = "after_rst";
        repeat (3) step(1'b0, LDA, 1'b0);
        tag = "forced";
        force dut.state = OP_FETCH;
        #1;
        release dut.state;
        ms = 3'd5;
        repeat (6) step(1'b0, ADD, 1'b0);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] kv;
            kv = k;
            tag = $sformatf("sweep_op%0d", k);
            step(1'b1, ADD, 1'b0);
            for (int j = 0; j < 24; j++) begin
                logic [31:0] jv;
                jv = j;
                step(1'b0, opcode_t'(kv[2:0]), jv[3] ^ kv[0]);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
